// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex -- parametrised single-clock FIFO with fill level,
// run-time almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : dout/dout_valid are registered, 1-cycle read latency.
//   defined   : first-word-fall-through, dout shows the head word while
//               dout_valid=~empty and rd_en pops it (0-cycle latency).
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   flush             synchronous clear of pointers and level (wins over rd/wr)
//   wr_en, din        write request and data
//   rd_en             read/pop request
//   dout, dout_valid  read data and its qualifier
//   afull_thresh      afull  = level >= afull_thresh
//   aempty_thresh     aempty = level <= aempty_thresh
//   level             number of stored words
//   empty, full       level == 0 / level == DEPTH
//   overflow          sticky: write attempted while full (no concurrent read)
//   underflow         sticky: read attempted while empty
//   err_clr           synchronous clear of both sticky flags (a new error wins)
//
// Handshake: wr_en is a request accepted when ~full, or when full and a read
// is accepted in the same cycle; rd_en is accepted when ~empty. Both are
// evaluated against the level held before the clock edge. A rejected request
// is not retried by the FIFO; it only raises the matching sticky flag.
module sync_fifo_flex #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic [LVL_W-1:0] afull_thresh,
  input  logic [LVL_W-1:0] aempty_thresh,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             aempty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Status flags depend only on the level register.
  assign level     = level_q;
  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign afull     = (level_q >= afull_thresh);
  assign aempty    = (level_q <= aempty_thresh);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    rd_acc      = rd_en & ~empty & ~flush;
    // When full, a simultaneous accepted read frees the slot being written.
    wr_acc      = wr_en & (~full | rd_acc) & ~flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (flush) begin
      // Errors attempted during a flush are deliberately not recorded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc)      level_d = level_q + LVL_W'(1);
      else if (rd_acc && !wr_acc) level_d = level_q - LVL_W'(1);
      if (wr_en && full && !rd_acc) overflow_d  = 1'b1;
      if (rd_en && empty)           underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; gated to zero while empty so dout never
  // exposes stale or uninitialised storage.
  assign dout       = empty ? '0 : mem_q[rd_ptr_q];
  assign dout_valid = ~empty;
`else
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      if (rd_acc) dout_q <= mem_q[rd_ptr_q];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [LVL_W-1:0] afull_thresh = LVL_W'(4);
  logic [LVL_W-1:0] aempty_thresh = LVL_W'(1);
  logic [LVL_W-1:0] level;
  logic             empty, full, afull, aempty, overflow, underflow;
  logic             err_clr = 1'b0;

  // clock / reset
  always #5 clock = ~clock;

  sync_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .level(level), .empty(empty), .full(full), .afull(afull), .aempty(aempty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  // scoreboard and reference state
  logic [WIDTH-1:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               m_level = 0;
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_state();
    chk("level", 32'(level), 32'(m_level));
    chk("empty", 32'(empty), 32'(m_level == 0));
    chk("full", 32'(full), 32'(m_level == DEPTH));
    chk("afull", 32'(afull), 32'(m_level >= int'(afull_thresh)));
    chk("aempty", 32'(aempty), 32'(m_level <= int'(aempty_thresh)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
`ifndef SYNC_FIFO_FWFT_EN
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  // driver: one clock cycle with the given controls, then check outputs
  task automatic cyc(input bit we, input logic [WIDTH-1:0] d, input bit re,
                     input bit fl, input bit ec);
    bit full_m, empty_m, rd_ok, wr_ok;
    logic [WIDTH-1:0] head;
    full_m  = (m_level == DEPTH);
    empty_m = (m_level == 0);
    rd_ok   = re && !empty_m && !fl;
    wr_ok   = we && (!full_m || rd_ok) && !fl;
    wr_en = we; din = d; rd_en = re; flush = fl; err_clr = ec;
`ifdef SYNC_FIFO_FWFT_EN
    #1;
    chk("fwft_valid", 32'(dout_valid), 32'(!empty_m));
    if (!empty_m) chk("fwft_dout", 32'(dout), 32'(exp_q[0]));
`endif
    head = '0;
    if (rd_ok) head = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    m_ovf = (m_ovf && !ec) || (we && full_m && !rd_ok && !fl);
    m_udf = (m_udf && !ec) || (re && empty_m && !fl);
    if (fl) begin
      exp_q.delete();
      m_level = 0;
    end else begin
      m_level = m_level + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end
    m_valid = rd_ok;
    if (rd_ok) m_dout = head;
    @(posedge clock);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_state();
  endtask

  initial begin
    // reset
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_state();
    chk("reset_dout", 32'(dout), 32'h0);
    cyc(0, '0, 0, 0, 0);

    // fill 0x11..0x55, then drain
    for (int i = 1; i <= 5; i++) cyc(1, WIDTH'(i * 8'h11), 0, 0, 0);
    chk("full_after_5", 32'(full), 32'h1);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);
    chk("empty_after_drain", 32'(empty), 32'h1);

    // pointer wrap: 4 rounds of write 3 / read 3
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cyc(1, WIDTH'(r * 3 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);
      chk("wrap_level0", 32'(level), 32'h0);
    end

    // overflow, rd+wr while full, underflow, err_clr
    for (int i = 1; i <= 5; i++) cyc(1, WIDTH'(i * 8'h11), 0, 0, 0);
    cyc(1, 8'h66, 0, 0, 0);
    chk("ovf_set", 32'(overflow), 32'h1);
    cyc(1, 8'h77, 1, 0, 0);
    chk("rdwr_full_dout", 32'(dout), 32'h11);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("udf_set", 32'(underflow), 32'h1);
    cyc(0, '0, 1, 0, 1);  // clear coincides with a new underflow: set wins
    chk("udf_set_wins", 32'(underflow), 32'h1);
    cyc(0, '0, 0, 0, 1);
    chk("ovf_clr", 32'(overflow), 32'h0);
    chk("udf_clr", 32'(underflow), 32'h0);
    cyc(1, 8'h5A, 1, 0, 0);  // rd+wr while empty: write only, underflow
    chk("rdwr_empty_udf", 32'(underflow), 32'h1);
    cyc(0, '0, 1, 0, 1);

    // thresholds
    afull_thresh = LVL_W'(4); aempty_thresh = LVL_W'(1);
    for (int i = 0; i < 3; i++) cyc(1, WIDTH'(8'hC0 + i), 0, 0, 0);
    afull_thresh = LVL_W'(2);
    #1;
    chk("afull_thresh_change", 32'(afull), 32'h1);
    afull_thresh = LVL_W'(4);
    for (int i = 3; i < 5; i++) cyc(1, WIDTH'(8'hC0 + i), 0, 0, 0);
    afull_thresh = '0; aempty_thresh = LVL_W'(DEPTH);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);
    chk("afull_forced", 32'(afull), 32'h1);
    chk("aempty_forced", 32'(aempty), 32'h1);
    afull_thresh = LVL_W'(4); aempty_thresh = LVL_W'(1);

    // flush at level 3 with concurrent write; errors during flush ignored
    for (int i = 0; i < 3; i++) cyc(1, WIDTH'(8'hE0 + i), 0, 0, 0);
    cyc(1, 8'h99, 0, 1, 0);
    chk("flush_empty", 32'(empty), 32'h1);
    cyc(0, '0, 1, 1, 0);
    chk("flush_no_udf", 32'(underflow), 32'h0);
    cyc(1, 8'hA5, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      afull_thresh  = LVL_W'($urandom_range(0, 7));
      aempty_thresh = LVL_W'($urandom_range(0, 7));
      cyc(bit'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 255)),
          bit'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
          $urandom_range(0, 15) == 0);
    end

    // asynchronous reset mid-operation
    cyc(1, 8'h3C, 0, 0, 0);
    cyc(1, 8'h4D, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    check_state();
    @(negedge clock);
    reset = 1'b0;
    cyc(0, '0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
